// File: rtl/stream_mux_arb_if.sv
// Stream multiplexer bus bundle: NCH valid/ready input channels in, one
// registered valid/ready output stream out, plus the select and lock controls.
interface stream_mux_arb_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [SELW-1:0]      sel;
    logic                 lock;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    // Multiplexer side of the bundle.
    modport slave (
        input  sel, lock, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    // Sources and downstream sink side of the bundle.
    modport master (
        output sel, lock, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer with external-select, round-robin
// and fixed-priority arbitration. One output register stage; a word accepted
// on an input is presented on the output the following cycle.
module stream_mux_arb #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    stream_mux_arb_if.slave   bus
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_rr_ptr;
    logic [SELW-1:0]  r_last_ch;

    logic [NCH-1:0]   w_gnt;
    logic [SELW-1:0]  w_gidx;
    logic [WIDTH-1:0] w_data;
    logic             w_can_load;
    logic             w_xfer;
    int               w_best;
    int               w_dist;
    logic             w_take;

    // Next round-robin start point; wraps explicitly so a non power-of-two
    // channel count never leaves the pointer on a missing channel.
    function automatic logic [SELW-1:0] ptr_inc(input logic [SELW-1:0] idx);
        logic [SELW-1:0] nxt;
        if (idx >= SELW'(NCH - 1)) begin
            nxt = {SELW{1'b0}};
        end else begin
            nxt = idx + SELW'(1);
        end
        return nxt;
    endfunction

    // Grant selection: lock pins the last channel, mode 0 follows sel, modes
    // 1/2 pick the valid channel with the smallest search distance (rotated
    // from the pointer for round-robin, plain index for fixed priority).
    always_comb begin
        w_gnt  = {NCH{1'b0}};
        w_gidx = {SELW{1'b0}};
        w_best = NCH;
        w_dist = 0;
        w_take = 1'b0;
        if ((MODE != 0) && bus.lock) begin
            w_gidx = r_last_ch;
            for (int i = 0; i < NCH; i++) begin
                w_gnt[i] = (r_last_ch == SELW'(i));
            end
        end else if (MODE == 0) begin
            w_gidx = bus.sel;
            for (int i = 0; i < NCH; i++) begin
                w_gnt[i] = (bus.sel == SELW'(i));
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (MODE == 1) begin
                    w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr))
                                                   : (i - int'(r_rr_ptr) + NCH);
                end else begin
                    w_dist = i;
                end
                w_take = bus.in_valid[i] && (w_dist < w_best);
                w_best = w_take ? w_dist : w_best;
                w_gidx = w_take ? SELW'(i) : w_gidx;
            end
            for (int i = 0; i < NCH; i++) begin
                w_gnt[i] = (w_best < NCH) && (w_gidx == SELW'(i));
            end
        end
    end

    // Data path mux for the granted channel.
    always_comb begin
        w_data = {WIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_data = (w_gidx == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : w_data;
        end
    end

    assign w_can_load   = ~r_out_valid | bus.out_ready;
    assign w_xfer       = (|(w_gnt & bus.in_valid)) & w_can_load & ~rst;
    assign bus.in_ready = (w_can_load & ~rst) ? w_gnt : {NCH{1'b0}};

    // Output register stage plus arbitration history (pointer, last channel).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_out_ch    <= {SELW{1'b0}};
            r_rr_ptr    <= {SELW{1'b0}};
            r_last_ch   <= {SELW{1'b0}};
        end else if (w_xfer) begin
            r_out_data  <= w_data;
            r_out_ch    <= w_gidx;
            r_out_valid <= 1'b1;
            r_last_ch   <= w_gidx;
            if (MODE == 1) begin
                r_rr_ptr <= ptr_inc(w_gidx);
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scenario bench for stream_mux_arb: five instances (modes 0/1/2 at NCH=4,
// modes 0/1 at NCH=3) with a queue of expected output words.
module tb_stream_mux_arb;
    localparam int W = 5;

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t e;

    stream_mux_arb_if #(.WIDTH(W), .NCH(4), .SELW(2)) if0 ();
    stream_mux_arb_if #(.WIDTH(W), .NCH(4), .SELW(2)) if1 ();
    stream_mux_arb_if #(.WIDTH(W), .NCH(4), .SELW(2)) if2 ();
    stream_mux_arb_if #(.WIDTH(W), .NCH(3), .SELW(2)) if3 ();
    stream_mux_arb_if #(.WIDTH(W), .NCH(3), .SELW(2)) if4 ();

    stream_mux_arb #(.WIDTH(W), .NCH(4), .SELW(2), .MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    stream_mux_arb #(.WIDTH(W), .NCH(4), .SELW(2), .MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    stream_mux_arb #(.WIDTH(W), .NCH(4), .SELW(2), .MODE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    stream_mux_arb #(.WIDTH(W), .NCH(3), .SELW(2), .MODE(0)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
    stream_mux_arb #(.WIDTH(W), .NCH(3), .SELW(2), .MODE(1)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.in_valid = 4'hF; if1.in_valid = 4'hF; if2.in_valid = 4'hF;
        if3.in_valid = 3'h7; if4.in_valid = 3'h7;
        if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        if3.out_ready = 1'b1; if4.out_ready = 1'b1;
        if1.in_data = 20'hABCDE;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready, if4.in_ready} !== 18'h0) begin
                errors++;
                $display("FAIL reset_in_ready got %b/%b/%b/%b/%b required all zero",
                         if0.in_ready, if1.in_ready, if2.in_ready, if3.in_ready, if4.in_ready);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        if0.in_valid = 4'h0; if1.in_valid = 4'h0; if2.in_valid = 4'h0;
        if3.in_valid = 3'h0; if4.in_valid = 3'h0;
        checks++;
        if ({if0.out_valid, if0.out_data, if0.out_ch, if1.out_valid, if1.out_data, if1.out_ch,
             if2.out_valid, if2.out_data, if2.out_ch} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h ch=%0d required zeros", if1.out_valid, if1.out_data, if1.out_ch);
        end
        checks++;
        if (u_dut1.r_rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_rr_ptr got %0d required 0", u_dut1.r_rr_ptr);
        end
        tick();
        checks++;
        if (if1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_valid got %b required 0", if1.out_valid);
        end
    endtask

    task automatic test_mode0_select();
        if0.in_data = {5'h1E, 5'h15, 5'h0A, 5'h01};
        if0.sel = 2'd2; if0.in_valid = 4'hF; if0.out_ready = 1'b1;
        sb_q.push_back(exp_t'({2'd2, 5'h15}));
        #1;
        checks++;
        if (if0.in_ready !== 4'b0100) begin errors++; $display("FAIL m0_ready_sel2 got %b required 0100", if0.in_ready); end
        tick();
        if0.sel = 2'd3;
        sb_q.push_back(exp_t'({2'd3, 5'h1E}));
        #1;
        checks++;
        if (if0.in_ready !== 4'b1000) begin errors++; $display("FAIL m0_ready_sel3 got %b required 1000", if0.in_ready); end
        for (int k = 0; k < 2; k++) begin
            if (if0.out_valid && if0.out_ready) begin
                checks++;
                if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
                if ({if0.out_ch, if0.out_data} !== e) begin errors++; $display("FAIL m0_word got %0d/%h required %0d/%h", if0.out_ch, if0.out_data, e.ch, e.data); end
            end
            tick();
            if (k == 0) if0.in_valid = 4'h0;
            #1;
        end
        checks++;
        if ({if0.out_valid, if0.out_ch, if0.out_data} !== {1'b0, 2'd3, 5'h1E}) begin
            errors++;
            $display("FAIL m0_drain_hold got v=%b ch=%0d d=%h required v=0 ch=3 d=1e", if0.out_valid, if0.out_ch, if0.out_data);
        end
        // sel beyond the channel count must never grant (NCH=3 instance)
        if3.in_data = {5'h03, 5'h02, 5'h01};
        if3.sel = 2'd3; if3.in_valid = 3'h7; if3.out_ready = 1'b1;
        #1;
        checks++;
        if (if3.in_ready !== 3'b000) begin errors++; $display("FAIL m0_sel_oob_ready got %b required 000", if3.in_ready); end
        tick();
        checks++;
        if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL m0_sel_oob_valid got %b required 0", if3.out_valid); end
        if3.sel = 2'd1;
        sb_q.push_back(exp_t'({2'd1, 5'h02}));
        #1;
        checks++;
        if (if3.in_ready !== 3'b010) begin errors++; $display("FAIL m0_n3_ready got %b required 010", if3.in_ready); end
        tick();
        if3.in_valid = 3'h0;
        #1;
        if (if3.out_valid && if3.out_ready) begin
            checks++;
            if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
            if ({if3.out_ch, if3.out_data} !== e) begin errors++; $display("FAIL m0_n3_word got %0d/%h required %0d/%h", if3.out_ch, if3.out_data, e.ch, e.data); end
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL m0_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
        tick();
    endtask

    task automatic test_round_robin();
        if1.in_data = {5'h13, 5'h12, 5'h11, 5'h10};
        if1.in_valid = 4'hF; if1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) sb_q.push_back(exp_t'({2'(k % 4), 5'(8'h10 + k % 4)}));
        #1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 5) if1.in_valid = 4'h0;
            #1;
            checks++;
            if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL rr_throughput cycle %0d got out_valid %b required 1", k, if1.out_valid); end
            if (if1.out_valid && if1.out_ready) begin
                checks++;
                if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
                if ({if1.out_ch, if1.out_data} !== e) begin errors++; $display("FAIL rr_word got %0d/%h required %0d/%h", if1.out_ch, if1.out_data, e.ch, e.data); end
            end
        end
        tick();
        checks++;
        if ({if1.out_valid, u_dut1.r_rr_ptr} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL rr_after got v=%b ptr=%0d required v=0 ptr=2", if1.out_valid, u_dut1.r_rr_ptr);
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL rr_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_backpressure();
        if1.in_valid = 4'hF; if1.out_ready = 1'b1;
        sb_q.push_back(exp_t'({2'd2, 5'h12}));
        #1;
        checks++;
        if (if1.in_ready !== 4'b0100) begin errors++; $display("FAIL bp_first_grant got %b required 0100", if1.in_ready); end
        tick();
        if1.out_ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({if1.out_valid, if1.out_ch, if1.out_data, if1.in_ready, u_dut1.r_rr_ptr} !== {1'b1, 2'd2, 5'h12, 4'h0, 2'd3}) begin
                errors++;
                $display("FAIL bp_stall cycle %0d got v=%b ch=%0d d=%h rdy=%b ptr=%0d required v=1 ch=2 d=12 rdy=0000 ptr=3",
                         s, if1.out_valid, if1.out_ch, if1.out_data, if1.in_ready, u_dut1.r_rr_ptr);
            end
            tick();
        end
        if1.out_ready = 1'b1;
        sb_q.push_back(exp_t'({2'd3, 5'h13}));
        #1;
        checks++;
        if (if1.in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_grant got %b required 1000", if1.in_ready); end
        for (int k = 0; k < 2; k++) begin
            if (if1.out_valid && if1.out_ready) begin
                checks++;
                if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
                if ({if1.out_ch, if1.out_data} !== e) begin errors++; $display("FAIL bp_word got %0d/%h required %0d/%h", if1.out_ch, if1.out_data, e.ch, e.data); end
            end
            tick();
            if (k == 0) if1.in_valid = 4'h0;
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL bp_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
        tick();
    endtask

    task automatic test_priority_lock();
        if2.in_data = {5'h00, 5'h00, 5'h06, 5'h05};
        if2.in_valid = 4'b0010; if2.out_ready = 1'b1; if2.lock = 1'b0;
        sb_q.push_back(exp_t'({2'd1, 5'h06}));
        #1;
        checks++;
        if (if2.in_ready !== 4'b0010) begin errors++; $display("FAIL lock_first got %b required 0010", if2.in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            case (k)
                0: begin if2.lock = 1'b1; if2.in_valid = 4'b0011; if2.in_data[9:5] = 5'h07; sb_q.push_back(exp_t'({2'd1, 5'h07})); end
                1: if2.in_valid = 4'b0001;
                2: begin if2.lock = 1'b0; sb_q.push_back(exp_t'({2'd0, 5'h05})); end
                default: if2.in_valid = 4'b0000;
            endcase
            #1;
            checks++;
            if (k < 2 && if2.in_ready !== 4'b0010) begin errors++; $display("FAIL lock_hold step %0d got %b required 0010", k, if2.in_ready); end
            else if (k == 2 && {if2.in_ready, if2.out_valid} !== {4'b0001, 1'b0}) begin
                errors++;
                $display("FAIL lock_release got rdy=%b v=%b required rdy=0001 v=0", if2.in_ready, if2.out_valid);
            end
            if (if2.out_valid && if2.out_ready) begin
                checks++;
                if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
                if ({if2.out_ch, if2.out_data} !== e) begin errors++; $display("FAIL lock_word got %0d/%h required %0d/%h", if2.out_ch, if2.out_data, e.ch, e.data); end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL lock_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
        tick();
    endtask

    task automatic test_rr_wrap_nch3();
        if4.in_data = {5'h1A, 5'h19, 5'h18};
        if4.in_valid = 3'h7; if4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) sb_q.push_back(exp_t'({2'(k % 3), 5'(8'h18 + k % 3)}));
        #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) if4.in_valid = 3'h0;
            #1;
            if (if4.out_valid && if4.out_ready) begin
                checks++;
                if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
                if ({if4.out_ch, if4.out_data} !== e) begin errors++; $display("FAIL wrap3_word got %0d/%h required %0d/%h", if4.out_ch, if4.out_data, e.ch, e.data); end
            end
        end
        tick();
        checks++;
        if (u_dut4.r_rr_ptr !== 2'd1) begin errors++; $display("FAIL wrap3_ptr got %0d required 1", u_dut4.r_rr_ptr); end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL wrap3_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_reset_midstream();
        if1.in_data = {5'h13, 5'h12, 5'h11, 5'h10};
        if1.in_valid = 4'b0100; if1.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        if1.in_valid = 4'hF;
        #1;
        checks++;
        if ({if1.in_ready, if1.out_valid} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL mid_rst_cycle got rdy=%b v=%b required rdy=0000 v=1", if1.in_ready, if1.out_valid);
        end
        tick();
        rst = 1'b0;
        if1.out_ready = 1'b1;
        if1.in_valid = 4'b0101;
        sb_q.push_back(exp_t'({2'd0, 5'h10}));
        #1;
        checks++;
        if ({if1.out_valid, if1.out_data, u_dut1.r_rr_ptr, if1.in_ready} !== {1'b0, 5'h00, 2'd0, 4'b0001}) begin
            errors++;
            $display("FAIL mid_rst_after got v=%b d=%h ptr=%0d rdy=%b required v=0 d=00 ptr=0 rdy=0001",
                     if1.out_valid, if1.out_data, u_dut1.r_rr_ptr, if1.in_ready);
        end
        tick();
        if1.in_valid = 4'h0;
        #1;
        if (if1.out_valid && if1.out_ready) begin
            checks++;
            if (sb_q.size() > 0) e = sb_q.pop_front(); else e = '1;
            if ({if1.out_ch, if1.out_data} !== e) begin errors++; $display("FAIL mid_word got %0d/%h required %0d/%h", if1.out_ch, if1.out_data, e.ch, e.data); end
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL mid_pending got %0d words required 0", sb_q.size()); sb_q.delete(); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        if0.sel = 2'd0; if0.lock = 1'b0; if0.in_data = '0; if0.in_valid = '0; if0.out_ready = 1'b0;
        if1.sel = 2'd0; if1.lock = 1'b0; if1.in_data = '0; if1.in_valid = '0; if1.out_ready = 1'b0;
        if2.sel = 2'd0; if2.lock = 1'b0; if2.in_data = '0; if2.in_valid = '0; if2.out_ready = 1'b0;
        if3.sel = 2'd0; if3.lock = 1'b0; if3.in_data = '0; if3.in_valid = '0; if3.out_ready = 1'b0;
        if4.sel = 2'd0; if4.lock = 1'b0; if4.in_data = '0; if4.in_valid = '0; if4.out_ready = 1'b0;
        test_reset();
        test_mode0_select();
        test_round_robin();
        test_backpressure();
        test_priority_lock();
        test_rr_wrap_nch3();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
